// File: rtl/id_ex_operand_reg_if.sv
// ID/EX operand register bus: ID-stage inputs, forwarding sources and EX-stage outputs.
interface id_ex_operand_reg_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int OP_WIDTH       = 4,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      stall, flush;
  logic                      inValid;
  logic [OP_WIDTH-1:0]       inAluFunc;
  logic [DATA_WIDTH-1:0]     inRsData, inRtData, inImm;
  logic                      inAluSrc;
  logic [REG_ADDR_WIDTH-1:0] inRs, inRt, inRd;
  logic                      inRegWrite, inMemRead, inMemWrite;
  logic                      exMemRegWrite;
  logic [REG_ADDR_WIDTH-1:0] exMemRd;
  logic [DATA_WIDTH-1:0]     exMemAluOut;
  logic                      memWbRegWrite;
  logic [REG_ADDR_WIDTH-1:0] memWbRd;
  logic [DATA_WIDTH-1:0]     memWbData;
  logic                      hazard, outValid;
  logic [OP_WIDTH-1:0]       aluFunc;
  logic [DATA_WIDTH-1:0]     A, B, storeData;
  logic [REG_ADDR_WIDTH-1:0] outRd;
  logic                      outRegWrite, outMemRead, outMemWrite;

  modport slave (
    input  stall, flush, inValid, inAluFunc, inRsData, inRtData, inImm, inAluSrc,
           inRs, inRt, inRd, inRegWrite, inMemRead, inMemWrite,
           exMemRegWrite, exMemRd, exMemAluOut, memWbRegWrite, memWbRd, memWbData,
    output hazard, outValid, aluFunc, A, B, storeData, outRd,
           outRegWrite, outMemRead, outMemWrite
  );

  modport master (
    output stall, flush, inValid, inAluFunc, inRsData, inRtData, inImm, inAluSrc,
           inRs, inRt, inRd, inRegWrite, inMemRead, inMemWrite,
           exMemRegWrite, exMemRd, exMemAluOut, memWbRegWrite, memWbRd, memWbData,
    input  hazard, outValid, aluFunc, A, B, storeData, outRd,
           outRegWrite, outMemRead, outMemWrite
  );
endinterface

// File: rtl/id_ex_operand_reg.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use hazard detection (one-cycle bubble).
module id_ex_operand_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int OP_WIDTH       = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic             clk,
  input logic             rst,
  id_ex_operand_reg_if.slave bus
);
  typedef struct packed {
    logic                      valid;
    logic [OP_WIDTH-1:0]       alu_func;
    logic [DATA_WIDTH-1:0]     rs_data;
    logic [DATA_WIDTH-1:0]     rt_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic                      alu_src;
    logic [REG_ADDR_WIDTH-1:0] rs;
    logic [REG_ADDR_WIDTH-1:0] rt;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
  } ex_state_t;

  ex_state_t q;
  logic uses_rt, hazard;
  logic [DATA_WIDTH-1:0] fwd_rs, fwd_rt;

  function automatic logic [DATA_WIDTH-1:0] fwd(
    input logic [REG_ADDR_WIDTH-1:0] idx,
    input logic [DATA_WIDTH-1:0]     latched,
    input logic                      ex_we,
    input logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input logic [DATA_WIDTH-1:0]     ex_data,
    input logic                      wb_we,
    input logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input logic [DATA_WIDTH-1:0]     wb_data
  );
    // r0 is hardwired: a stale writer to r0 must never leak into the ALU
    if (idx == '0)                 return latched;
    if (ex_we && ex_rd == idx)     return ex_data;
    if (wb_we && wb_rd == idx)     return wb_data;
    return latched;
  endfunction

  always_comb begin
    uses_rt = !bus.inAluSrc || bus.inMemWrite;
    hazard  = !bus.stall && !bus.flush && bus.inValid && q.valid && q.mem_read &&
              (q.rd != '0) &&
              ((bus.inRs == q.rd) || (uses_rt && bus.inRt == q.rd));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (bus.stall) begin
      q <= q;
    end else if (bus.flush || hazard) begin
      // bubble: data fields hold, only the control bits are cleared
      q.valid     <= 1'b0;
      q.reg_write <= 1'b0;
      q.mem_read  <= 1'b0;
      q.mem_write <= 1'b0;
    end else begin
      q.valid     <= bus.inValid;
      q.alu_func  <= bus.inAluFunc;
      q.rs_data   <= bus.inRsData;
      q.rt_data   <= bus.inRtData;
      q.imm       <= bus.inImm;
      q.alu_src   <= bus.inAluSrc;
      q.rs        <= bus.inRs;
      q.rt        <= bus.inRt;
      q.rd        <= bus.inRd;
      q.reg_write <= bus.inRegWrite & bus.inValid;
      q.mem_read  <= bus.inMemRead  & bus.inValid;
      q.mem_write <= bus.inMemWrite & bus.inValid;
    end
  end

  assign fwd_rs = fwd(q.rs, q.rs_data, bus.exMemRegWrite, bus.exMemRd, bus.exMemAluOut,
                      bus.memWbRegWrite, bus.memWbRd, bus.memWbData);
  assign fwd_rt = fwd(q.rt, q.rt_data, bus.exMemRegWrite, bus.exMemRd, bus.exMemAluOut,
                      bus.memWbRegWrite, bus.memWbRd, bus.memWbData);

  assign bus.hazard      = hazard;
  assign bus.outValid    = q.valid;
  assign bus.aluFunc     = q.alu_func;
  assign bus.A           = fwd_rs;
  assign bus.B           = q.alu_src ? q.imm : fwd_rt;
  assign bus.storeData   = fwd_rt;
  assign bus.outRd       = q.rd;
  assign bus.outRegWrite = q.reg_write & q.valid;
  assign bus.outMemRead  = q.mem_read  & q.valid;
  assign bus.outMemWrite = q.mem_write & q.valid;
endmodule

// File: doc/id_ex_operand_reg.md
Name: id_ex_operand_reg

Overview:
- ID/EX pipeline register for the 5-stage MIPS32 core; sits directly upstream of the ALU and drives its aluFunc, A and B inputs.
- Latches decoded fields and register-file read data from ID.
- Applies EX/MEM and MEM/WB forwarding to the ALU operands and the store data.
- Detects load-use hazards and inserts a one-cycle bubble.
- Carries the control bits that EX/MEM needs.

Parameters:
DATA_WIDTH, 32, operand/result width
OP_WIDTH, 4, ALU function code width (0000 ADD … 0111 NOR)
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  downstream freeze request; hold all state
flush  input  1  kill instruction being loaded (branch taken)
inValid  input  1  ID slot holds a real instruction
inAluFunc  input  OP_WIDTH  decoded ALU function
inRsData  input  DATA_WIDTH  register-file read port 1
inRtData  input  DATA_WIDTH  register-file read port 2
inImm  input  DATA_WIDTH  sign/zero-extended immediate
inAluSrc  input  1  1: B = immediate, 0: B = rt
inRs  input  REG_ADDR_WIDTH  source index 1
inRt  input  REG_ADDR_WIDTH  source index 2
inRd  input  REG_ADDR_WIDTH  destination index, already muxed rt/rd
inRegWrite  input  1  writes register file
inMemRead  input  1  load
inMemWrite  input  1  store
exMemRegWrite  input  1  EX/MEM will write back
exMemRd  input  REG_ADDR_WIDTH  EX/MEM destination
exMemAluOut  input  DATA_WIDTH  EX/MEM ALU result
memWbRegWrite  input  1  MEM/WB will write back
memWbRd  input  REG_ADDR_WIDTH  MEM/WB destination
memWbData  input  DATA_WIDTH  MEM/WB write-back data
hazard  output  1  load-use detected; IF and IF/ID must hold
outValid  output  1  EX slot valid
aluFunc  output  OP_WIDTH  to ALU
A  output  DATA_WIDTH  to ALU, forwarded rs
B  output  DATA_WIDTH  to ALU, immediate or forwarded rt
storeData  output  DATA_WIDTH  forwarded rt for stores
outRd  output  REG_ADDR_WIDTH  destination index
outRegWrite  output  1  gated by outValid
outMemRead  output  1  gated by outValid
outMemWrite  output  1  gated by outValid

Behaviour:
- Registered state: valid, aluFunc, rsData, rtData, imm, aluSrc, rs, rt, rd, regWrite, memRead, memWrite.
- Reset, when rst=1 at an edge: all state is 0. outValid, outRegWrite, outMemRead, outMemWrite, hazard and aluFunc all read 0. aluFunc=0 is ADD.
- Update priority at each edge: rst > stall (hold everything) > flush or hazard (load bubble) > normal load.
  - Bubble: valid, regWrite, memRead and memWrite are 0. Data fields are don't-care; implemented as hold.
  - Normal load: all fields take the in* values. Control bits are ANDed with inValid.
- Latency: one cycle from ID inputs to EX outputs.
- hazard is combinational. It is 1 when all of the following hold:
  - inValid = 1
  - valid = 1 and memRead = 1
  - rd != 0
  - inRs == rd, or (inRt == rd and the instruction uses rt)
  - "Uses rt" means inAluSrc = 0 or inMemWrite = 1.
- hazard is forced to 0 while stall = 1 and while flush = 1.
- Forwarding for the registered rs (A path) and rt (B path), evaluated every cycle including stall cycles:
  - The index must be nonzero.
  - If exMemRegWrite = 1 and exMemRd == index: use exMemAluOut (highest priority).
  - Else if memWbRegWrite = 1 and memWbRd == index: use memWbData.
  - Else use the registered read data.
- Register 0 is never forwarded; its value passes through as latched.
- B = imm when aluSrc = 1, else forwarded rt. storeData is always forwarded rt.
- outRegWrite, outMemRead and outMemWrite equal the registered bits ANDed with valid.
- Simultaneous cases:
  - flush and hazard both 1: a single bubble.
  - stall and flush both 1: stall wins. The flush must be held by its source until stall drops.
- A store immediately after a load to the same register triggers hazard (rt is used).

Test Plan:
- rst=1 for 2 cycles with random inputs -> outValid=0, aluFunc=0000, outRegWrite=0, outMemWrite=0, hazard=0.
- Load ADD, inRsData=5, inRtData=7, inAluSrc=0, no forwarding matches -> next cycle A=5, B=7, aluFunc=0000, outValid=1.
- Registered rs=3; exMemRegWrite=1, exMemRd=3, exMemAluOut=0x11; memWbRegWrite=1, memWbRd=3, memWbData=0x22 -> A=0x11. Drop exMemRegWrite -> A=0x22. Same test with rs=0 -> A = latched data.
- EX holds lw with rd=8; ID presents add with inRs=8, inValid=1 -> hazard=1. Next cycle outValid=0 and outRegWrite=0. Following cycle the add loads normally with hazard=0.
- flush=1 while loading a valid sw -> next cycle outValid=0, outMemWrite=0. stall=1 together with flush -> all outputs unchanged.
- addi with inAluSrc=1, inImm=0xFFFFFFFC, inRt=inRd=9 -> B=0xFFFFFFFC and hazard ignores inRt. sw with inRt=9 after a lw to r9 -> hazard=1.
